ssd_state_ctrl: RTL

- Upstream control stage that produces the 4-bit display state code consumed by the SSD display block.
- Debounces raw push-buttons and steps a user state through 0..NUM_STATES-1, either manually or by timed auto-cycling.
- A synchronized alarm input overrides the output with a dedicated alarm state.
- Runs on the 1 MHz clkus domain.

---
 rtl/ssd_state_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ssd_state_ctrl.sv
// Display state controller: debounced next/prev/auto buttons step a user state,
// optional timed auto-advance, and a synchronized alarm that overrides the code.
module ssd_state_ctrl #(
    parameter int unsigned DEBOUNCE    = 20000,
    parameter int unsigned AUTO_PERIOD = 3000000,
    parameter int unsigned NUM_STATES  = 9,
    parameter int unsigned ALARM_STATE = 9
) (
    input  logic       clkus,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_auto,
    input  logic       alarm,
    output logic [3:0] state,
    output logic       auto_on,
    output logic       state_chg
);
    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned TmrW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE - 1);
    localparam logic [TmrW-1:0] TmrLast   = TmrW'(AUTO_PERIOD - 1);
    localparam logic [3:0]      LastState = 4'(NUM_STATES - 1);
    localparam logic [3:0]      AlarmCode = 4'(ALARM_STATE);

    // Bit order in sync/debounce vectors: 0 next, 1 prev, 2 auto, 3 alarm.
    logic [3:0]      r_s1;
    logic [3:0]      r_s2;
    logic [CntW-1:0] r_deb_cnt [3];
    logic [2:0]      r_stable;
    logic [2:0]      r_press;
    logic            r_alarm_q;
    logic [3:0]      r_cur;
    logic [TmrW-1:0] r_timer;
    logic            r_auto;
    logic [3:0]      r_state;
    logic            r_chg;

    logic            w_alarm_s;
    logic            w_manual;
    logic            w_expire;
    logic [3:0]      w_cur_inc;
    logic [3:0]      w_cur_dec;
    logic [3:0]      w_cur_d;
    logic            w_auto_d;
    logic [TmrW-1:0] w_timer_d;
    logic [3:0]      w_state_d;

    always_ff @(posedge clkus) begin
        if (!rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_press  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= {alarm, btn_auto, btn_prev, btn_next};
            r_s2 <= r_s1;
            for (int i = 0; i < 3; i++) begin
                r_press[i] <= 1'b0;
                if (r_s2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DebLast) begin
                    r_deb_cnt[i] <= '0;
                    r_stable[i]  <= r_s2[i];
                    r_press[i]   <= r_s2[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CntW'(1);
                end
            end
        end
    end

    assign w_alarm_s = r_s2[3];
    assign w_manual  = r_press[0] | r_press[1];
    // No expiry in the first cycle after alarm exit: the period restarts from zero there.
    assign w_expire  = r_auto && !r_alarm_q && (r_timer == TmrLast);
    assign w_cur_inc = (r_cur == LastState) ? 4'd0 : r_cur + 4'd1;
    assign w_cur_dec = (r_cur == 4'd0) ? LastState : r_cur - 4'd1;

    always_comb begin
        w_cur_d   = r_cur;
        w_auto_d  = r_auto;
        w_timer_d = '0;
        w_state_d = AlarmCode;
        if (!w_alarm_s) begin
            if (r_auto && !w_manual && !r_alarm_q && !w_expire) begin
                w_timer_d = r_timer + TmrW'(1);
            end
            if (r_press[0] && !r_press[1]) begin
                w_cur_d = w_cur_inc;
            end else if (r_press[1] && !r_press[0]) begin
                w_cur_d = w_cur_dec;
            end else if (!w_manual && w_expire) begin
                w_cur_d = w_cur_inc;
            end
            if (r_press[2]) begin
                w_auto_d  = ~r_auto;
                w_timer_d = '0;
            end
            w_state_d = w_cur_d;
        end
    end

    always_ff @(posedge clkus) begin
        if (!rst_n) begin
            r_alarm_q <= 1'b0;
            r_cur     <= '0;
            r_timer   <= '0;
            r_auto    <= 1'b0;
            r_state   <= '0;
            r_chg     <= 1'b0;
        end else begin
            r_alarm_q <= w_alarm_s;
            r_cur     <= w_cur_d;
            r_timer   <= w_timer_d;
            r_auto    <= w_auto_d;
            r_state   <= w_state_d;
            r_chg     <= (w_state_d != r_state);
        end
    end

    assign state     = r_state;
    assign auto_on   = r_auto;
    assign state_chg = r_chg;
endmodule
